fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
PC register, next-PC selector and F/D pipeline register for the P7 five-stage MIPS core.
- Consumes the D-stage branch decision (`zero` from the comparator) and the jump/eret controls.
- Produces the fetch address for instruction memory and the D-stage instruction/PC bundle.
- Handles the branch delay slot (BD flag), exception-handler entry, eret return, and AdEL detection on instruction fetch.

Parameters:
- PC_RESET, 32'h0000_3000, PC value after reset
- EXC_ENTRY, 32'h0000_4180, exception handler address
- IM_LO, 32'h0000_3000, lowest legal fetch address
- IM_HI, 32'h0000_6FFC, highest legal fetch address

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-low; state resets when reset==0 at posedge clk
- stall  in  1  hazard unit: hold PC and F/D register
- exc_req  in  1  CP0 exception/interrupt taken this cycle
- eret_d  in  1  eret is in D
- epc  in  32  CP0 EPC
- br_d  in  1  D instr is a conditional branch
- zero  in  1  comparator result; meaningful only when br_d==1
- imm16_d  in  16  branch offset field of D instr
- j_d  in  1  D instr is j/jal
- index_d  in  26  jump target field
- jr_d  in  1  D instr is jr/jalr
- rs_val_d  in  32  forwarded rs value in D
- instr_f  in  32  instruction memory read data at pc_f
- pc_f  out  32  fetch address
- instr_d  out  32  D-stage instruction
- pc_d  out  32  D-stage PC
- bd_d  out  1  D instr sits in a delay slot
- adel_d  out  1  D instr had a fetch address error

Behaviour:
- Reset: pc_f=PC_RESET; instr_d=0; pc_d=0; bd_d=0; adel_d=0.
- Per-edge priority: reset > exc_req > stall > eret_d > normal.
- exc_req (overrides stall):
  - pc_f<=EXC_ENTRY.
  - instr_d<=0, pc_d<=0, bd_d<=0, adel_d<=0.
- stall, no exc_req: all registers hold; br_d/zero/j_d/jr_d are ignored that cycle.
- eret_d, no stall:
  - pc_f<=epc.
  - The instruction fetched after eret is discarded (eret has no delay slot): instr_d<=0, pc_d<=0, bd_d<=0, adel_d<=0.
- Normal advance:
  - pc_d<=pc_f.
  - bd_d<=(br_d|j_d|jr_d); the slot is marked whether or not the branch is taken.
  - If fetch_err: instr_d<=0, adel_d<=1. Otherwise instr_d<=instr_f, adel_d<=0.
- fetch_err = (pc_f[1:0]!=0) | (pc_f<IM_LO) | (pc_f>IM_HI). Unsigned compare.
- Next PC in normal advance, first match wins:
  - jr_d: rs_val_d, no alignment fix-up; a misaligned value yields AdEL on the next fetch.
  - j_d: {pc_d[31:28], index_d, 2'b00}.
  - br_d & zero: pc_d + 4 + {{14{imm16_d[15]}}, imm16_d, 2'b00}, mod 2^32.
  - else: pc_f + 4, mod 2^32; wrap-around is permitted.
- Control-flow latency: the target is fetched in the cycle after the delay slot is fetched, i.e. one cycle after the branch resolves in D.
- zero is never sampled when br_d==0, so a Z value must not propagate; use a `br_d & (zero===1'b1)`-safe gate.
- Branch held in D by stall: the target is computed only on the cycle stall deasserts, using zero as sampled then.
- Reset asserted mid-stall or mid-exception: the reset values win.

Decomposition:
- Shared constants package holds PC_RESET, EXC_ENTRY, IM_LO, IM_HI and the NOP encoding (32'h0).
- Natural sub-module: next_pc_sel, purely combinational; computes target and fetch_err from pc_f, pc_d and the control inputs.
- The parent holds pc_f and the F/D register.

Test Plan:
- Reset, then 3 free-running cycles: pc_f sequence 0x3000→0x3004→0x3008, then 0x300C; instr_d tracks instr_f delayed one cycle, bd_d=0.
- beq in D, pc_d=0x3010, imm16=0x0003, zero=1: delay slot at pc_f 0x3014 reaches D with bd_d=1; next pc_f=0x3020.
  - Same stimulus with zero=0: next pc_f=0x3018.
- jr with rs_val_d=0x3001 in D: next pc_f=0x3001; following cycle adel_d=1, instr_d=0, pc_d=0x3001.
- stall held 2 cycles with j_d in D: pc_f, instr_d, pc_d frozen. On release, pc_f={pc_d[31:28],index_d,00} and bd_d=1 for the slot.
- exc_req together with stall and eret_d: pc_f=0x4180, instr_d=0, bd_d=0.
  - Next cycle, eret_d with epc=0x3040: pc_f=0x3040 and the post-eret fetch is squashed (instr_d=0).
- Fetch at pc_f=0x6FFC: no error. Sequential advance to 0x7000 gives adel_d=1 the following cycle.
- reset pulled low mid-stall: all outputs return to reset values on that edge.

Source files
------------

// File: rtl/fetch_pc_unit_pkg.sv
// Shared constants for the fetch / PC unit of the P7 five-stage core.
//   - Default reset PC, exception entry point and legal instruction-memory window
//   - NOP encoding used to squash the F/D register
//   - Helper that sign-extends and word-scales a 16-bit branch offset
package fetch_pc_unit_pkg;

    localparam logic [31:0] PC_RESET_DEF  = 32'h0000_3000;
    localparam logic [31:0] EXC_ENTRY_DEF = 32'h0000_4180;
    localparam logic [31:0] IM_LO_DEF     = 32'h0000_3000;
    localparam logic [31:0] IM_HI_DEF     = 32'h0000_6FFC;
    localparam logic [31:0] NOP_INSTR     = 32'h0000_0000;
    localparam logic [31:0] INSTR_BYTES   = 32'd4;

    function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
        return {{14{imm16[15]}}, imm16, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pc_unit_next_pc_sel.sv
// Combinational next-PC selector and fetch-address checker.
// Ports:
//   pc_f, pc_d       current fetch PC and D-stage PC
//   br_d, zero       conditional branch in D and its comparator result
//   imm16_d          branch offset field
//   j_d, index_d     j/jal in D and its 26-bit target field
//   jr_d, rs_val_d   jr/jalr in D and forwarded rs value
//   next_pc          fetch address for the next normal advance
//   fetch_err        current pc_f is misaligned or outside instruction memory
module fetch_pc_unit_next_pc_sel
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [31:0] IM_LO = IM_LO_DEF,
    parameter logic [31:0] IM_HI = IM_HI_DEF
) (
    input  logic [31:0] pc_f,
    input  logic [31:0] pc_d,
    input  logic        br_d,
    input  logic        zero,
    input  logic [15:0] imm16_d,
    input  logic        j_d,
    input  logic [25:0] index_d,
    input  logic        jr_d,
    input  logic [31:0] rs_val_d,
    output logic [31:0] next_pc,
    output logic        fetch_err
);

    logic taken;

    // zero is only meaningful for branches; an X/Z on it must never steer the PC.
    assign taken = br_d & (zero === 1'b1);

    always_comb begin
        next_pc = pc_f + INSTR_BYTES;
        if (jr_d) begin
            // No alignment fix-up: a bad register value surfaces as AdEL on fetch.
            next_pc = rs_val_d;
        end else if (j_d) begin
            next_pc = {pc_d[31:28], index_d, 2'b00};
        end else if (taken) begin
            next_pc = pc_d + INSTR_BYTES + branch_offset(imm16_d);
        end
    end

    assign fetch_err = (pc_f[1:0] != 2'b00) | (pc_f < IM_LO) | (pc_f > IM_HI);

endmodule

// File: rtl/fetch_pc_unit.sv
// PC register, next-PC selection and F/D pipeline register.
// Ports:
//   clk, reset        clock; synchronous active-low reset
//   stall             hold PC and F/D register
//   exc_req           exception/interrupt taken: redirect to handler, squash F/D
//   eret_d, epc       eret in D: return to epc, squash the fetched instruction
//   br_d, zero, imm16_d, j_d, index_d, jr_d, rs_val_d   D-stage control-flow info
//   instr_f           instruction memory data at pc_f
//   pc_f              fetch address
//   instr_d, pc_d     D-stage instruction and PC
//   bd_d              D instruction is in a branch delay slot
//   adel_d            D instruction had a fetch address error
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [31:0] PC_RESET  = PC_RESET_DEF,
    parameter logic [31:0] EXC_ENTRY = EXC_ENTRY_DEF,
    parameter logic [31:0] IM_LO     = IM_LO_DEF,
    parameter logic [31:0] IM_HI     = IM_HI_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        exc_req,
    input  logic        eret_d,
    input  logic [31:0] epc,
    input  logic        br_d,
    input  logic        zero,
    input  logic [15:0] imm16_d,
    input  logic        j_d,
    input  logic [25:0] index_d,
    input  logic        jr_d,
    input  logic [31:0] rs_val_d,
    input  logic [31:0] instr_f,
    output logic [31:0] pc_f,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic        bd_d,
    output logic        adel_d
);

    logic [31:0] next_pc;
    logic        fetch_err;

    fetch_pc_unit_next_pc_sel #(
        .IM_LO (IM_LO),
        .IM_HI (IM_HI)
    ) u_next_pc_sel (
        .pc_f      (pc_f),
        .pc_d      (pc_d),
        .br_d      (br_d),
        .zero      (zero),
        .imm16_d   (imm16_d),
        .j_d       (j_d),
        .index_d   (index_d),
        .jr_d      (jr_d),
        .rs_val_d  (rs_val_d),
        .next_pc   (next_pc),
        .fetch_err (fetch_err)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_f    <= PC_RESET;
            instr_d <= NOP_INSTR;
            pc_d    <= 32'h0;
            bd_d    <= 1'b0;
            adel_d  <= 1'b0;
        end else if (exc_req) begin
            // Exception wins over stall so the handler entry is never lost.
            pc_f    <= EXC_ENTRY;
            instr_d <= NOP_INSTR;
            pc_d    <= 32'h0;
            bd_d    <= 1'b0;
            adel_d  <= 1'b0;
        end else if (!stall) begin
            if (eret_d) begin
                // eret has no delay slot: the instruction fetched alongside it is dropped.
                pc_f    <= epc;
                instr_d <= NOP_INSTR;
                pc_d    <= 32'h0;
                bd_d    <= 1'b0;
                adel_d  <= 1'b0;
            end else begin
                pc_f   <= next_pc;
                pc_d   <= pc_f;
                // Slot is marked regardless of whether the branch is taken.
                bd_d   <= br_d | j_d | jr_d;
                adel_d <= fetch_err;
                instr_d <= fetch_err ? NOP_INSTR : instr_f;
            end
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, exc_req, eret_d, br_d, zero, j_d, jr_d;
    logic [31:0] epc, rs_val_d, instr_f;
    logic [15:0] imm16_d;
    logic [25:0] index_d;
    logic [31:0] pc_f, instr_d, pc_d;
    logic        bd_d, adel_d;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int          tag;
        logic [31:0] pc_f;
        logic [31:0] instr_d;
        logic [31:0] pc_d;
        logic        bd_d;
        logic        adel_d;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instruction memory model: the word returned encodes its own address.
    function automatic logic [31:0] imem(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    assign instr_f = imem(pc_f);

    fetch_pc_unit dut (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .exc_req  (exc_req),
        .eret_d   (eret_d),
        .epc      (epc),
        .br_d     (br_d),
        .zero     (zero),
        .imm16_d  (imm16_d),
        .j_d      (j_d),
        .index_d  (index_d),
        .jr_d     (jr_d),
        .rs_val_d (rs_val_d),
        .instr_f  (instr_f),
        .pc_f     (pc_f),
        .instr_d  (instr_d),
        .pc_d     (pc_d),
        .bd_d     (bd_d),
        .adel_d   (adel_d)
    );

    task automatic chk(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, tag, act, exp);
        end
    endtask

    // Monitor: compares the DUT outputs against any expectation due this cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].tag <= cyc) begin
                e = exp_q.pop_front();
                if (e.tag < cyc) begin
                    errors++;
                    $display("FAIL stale_expectation: tag %0d seen at cycle %0d", e.tag, cyc);
                end else begin
                    chk("pc_f",    e.tag, pc_f,           e.pc_f);
                    chk("instr_d", e.tag, instr_d,        e.instr_d);
                    chk("pc_d",    e.tag, pc_d,           e.pc_d);
                    chk("bd_d",    e.tag, {31'b0, bd_d},   {31'b0, e.bd_d});
                    chk("adel_d",  e.tag, {31'b0, adel_d}, {31'b0, e.adel_d});
                end
            end
        end
    end

    task automatic clr();
        stall = 0; exc_req = 0; eret_d = 0; br_d = 0; j_d = 0; jr_d = 0;
        zero = 1'bz;
    endtask

    // Push the state expected after the next rising edge, then advance one cycle.
    task automatic step(input logic [31:0] e_pc_f, input logic [31:0] e_instr,
                        input logic [31:0] e_pc_d, input logic e_bd, input logic e_adel);
        exp_t e;
        e.tag = cyc + 1; e.pc_f = e_pc_f; e.instr_d = e_instr; e.pc_d = e_pc_d;
        e.bd_d = e_bd; e.adel_d = e_adel;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        clr();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr();
        reset = 0; epc = 0; imm16_d = 0; index_d = 0; rs_val_d = 0;
        @(posedge clk); #1;
        step(32'h3000, 32'h0, 32'h0, 0, 0);
        reset = 1;

        // Free-running sequential fetch
        step(32'h3004, imem(32'h3000), 32'h3000, 0, 0);
        step(32'h3008, imem(32'h3004), 32'h3004, 0, 0);
        step(32'h300C, imem(32'h3008), 32'h3008, 0, 0);
        step(32'h3010, imem(32'h300C), 32'h300C, 0, 0);
        step(32'h3014, imem(32'h3010), 32'h3010, 0, 0);

        // beq at 0x3010 taken, imm 3 -> 0x3020
        br_d = 1; zero = 1; imm16_d = 16'h0003;
        step(32'h3020, imem(32'h3014), 32'h3014, 1, 0);
        step(32'h3024, imem(32'h3020), 32'h3020, 0, 0);

        // Return to 0x300C via jr, then same beq not taken
        jr_d = 1; rs_val_d = 32'h300C;
        step(32'h300C, imem(32'h3024), 32'h3024, 1, 0);
        step(32'h3010, imem(32'h300C), 32'h300C, 0, 0);
        step(32'h3014, imem(32'h3010), 32'h3010, 0, 0);
        br_d = 1; zero = 0; imm16_d = 16'h0003;
        step(32'h3018, imem(32'h3014), 32'h3014, 1, 0);
        // branch with undriven zero must not be taken
        br_d = 1; imm16_d = 16'h0003;
        step(32'h301C, imem(32'h3018), 32'h3018, 1, 0);

        // jr to misaligned address -> AdEL on the following fetch
        jr_d = 1; rs_val_d = 32'h3001;
        step(32'h3001, imem(32'h301C), 32'h301C, 1, 0);
        step(32'h3005, 32'h0, 32'h3001, 0, 1);
        jr_d = 1; rs_val_d = 32'h3030;
        step(32'h3030, 32'h0, 32'h3005, 1, 1);
        step(32'h3034, imem(32'h3030), 32'h3030, 0, 0);

        // j held in D by a 2-cycle stall; branch inputs ignored while stalled
        stall = 1; j_d = 1; index_d = 26'h0000C10; br_d = 1; zero = 1; imm16_d = 16'h0040;
        step(32'h3034, imem(32'h3030), 32'h3030, 0, 0);
        stall = 1; j_d = 1; index_d = 26'h0000C10;
        step(32'h3034, imem(32'h3030), 32'h3030, 0, 0);
        j_d = 1; index_d = 26'h0000C10;
        step(32'h3040, imem(32'h3034), 32'h3034, 1, 0);

        // exception beats stall and eret, then eret squashes the next fetch
        exc_req = 1; stall = 1; eret_d = 1; epc = 32'h3040;
        step(32'h4180, 32'h0, 32'h0, 0, 0);
        eret_d = 1; epc = 32'h3040;
        step(32'h3040, 32'h0, 32'h0, 0, 0);
        step(32'h3044, imem(32'h3040), 32'h3040, 0, 0);

        // Upper edge of instruction memory
        jr_d = 1; rs_val_d = 32'h6FF8;
        step(32'h6FF8, imem(32'h3044), 32'h3044, 1, 0);
        step(32'h6FFC, imem(32'h6FF8), 32'h6FF8, 0, 0);
        step(32'h7000, imem(32'h6FFC), 32'h6FFC, 0, 0);
        step(32'h7004, 32'h0, 32'h7000, 0, 1);

        // Below lower edge
        jr_d = 1; rs_val_d = 32'h2FFC;
        step(32'h2FFC, 32'h0, 32'h7004, 1, 1);
        step(32'h3000, 32'h0, 32'h2FFC, 0, 1);

        // Wrap-around, then j using pc_d upper bits
        jr_d = 1; rs_val_d = 32'hFFFF_FFFC;
        step(32'hFFFF_FFFC, imem(32'h3000), 32'h3000, 1, 0);
        step(32'h0000_0000, 32'h0, 32'hFFFF_FFFC, 0, 1);
        j_d = 1; index_d = 26'h0000C10;
        step(32'hF000_3040, 32'h0, 32'h0000_0000, 1, 1);

        // Reset asserted during a stall
        stall = 1;
        step(32'hF000_3040, 32'h0, 32'h0000_0000, 1, 1);
        stall = 1; exc_req = 0; reset = 0;
        step(32'h3000, 32'h0, 32'h0, 0, 0);
        reset = 1;
        step(32'h3004, imem(32'h3000), 32'h3000, 0, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        @(negedge clk); #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d expectations unchecked, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
